cpu_program_loader: RTL and testbench

Boot-time loader that sits directly upstream of the cpu top. It accepts a byte stream over a valid/ready interface and assembles it into 32-bit instruction words and 64-bit data words. It writes those words into instruction and data memory through the cpu's external memory ports (addr_ext/wen_ext/wdata_ext and addr_ext_2/wen_ext_2/wdata_ext_2). Once a trailer checksum verifies, it asserts the cpu enable.

---
 rtl/cpu_program_loader.sv | 167 ++++++++++++++++
 tb/tb_cpu_program_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_program_loader.sv
// Boot-time byte-stream loader: assembles instruction/data words, writes them through the
// cpu external memory ports, and enables the cpu once the trailer XOR checksum matches.
module cpu_program_loader #(
   parameter int IMEM_WORDS = 128,
   parameter int DMEM_WORDS = 128
) (
   input  logic        clk,
   input  logic        arst_n,
   input  logic        start,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [63:0] addr_ext,
   output logic        wen_ext,
   output logic        ren_ext,
   output logic [31:0] wdata_ext,
   output logic [63:0] addr_ext_2,
   output logic        wen_ext_2,
   output logic        ren_ext_2,
   output logic [63:0] wdata_ext_2,
   output logic        cpu_enable,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_IMEM  = 3'd2;
   localparam logic [2:0] S_DMEM  = 3'd3;
   localparam logic [2:0] S_CKSUM = 3'd4;
   localparam logic [2:0] S_RUN   = 3'd5;
   localparam logic [2:0] S_ERROR = 3'd6;

   localparam logic [31:0] IMEM_MAX = 32'(IMEM_WORDS);
   localparam logic [31:0] DMEM_MAX = 32'(DMEM_WORDS);

   logic [2:0]  state;
   logic [2:0]  byte_cnt;
   logic [15:0] n_i;
   logic [15:0] n_d;
   logic [15:0] k;
   logic [55:0] asm_word;
   logic [7:0]  cksum;
   logic        accept;
   logic [15:0] n_d_full;
   logic [2:0]  hdr_next;

   assign accept     = s_valid & s_ready;
   assign s_ready    = (state == S_HDR) || (state == S_IMEM) ||
                       (state == S_DMEM) || (state == S_CKSUM);
   assign busy       = s_ready;
   assign done       = (state == S_RUN);
   assign cpu_enable = (state == S_RUN);
   assign error      = (state == S_ERROR);
   assign ren_ext    = 1'b0;
   assign ren_ext_2  = 1'b0;

   // The 4th header byte completes n_d in the same cycle the section decision is made.
   assign n_d_full = {s_data, n_d[7:0]};

   always_comb begin
      hdr_next = S_CKSUM;
      if ((32'(n_i) > IMEM_MAX) || (32'(n_d_full) > DMEM_MAX))
         hdr_next = S_ERROR;
      else if (n_i != 16'd0)
         hdr_next = S_IMEM;
      else if (n_d_full != 16'd0)
         hdr_next = S_DMEM;
   end

   always_ff @(posedge clk) begin
      if (arst_n) begin
         state       <= S_IDLE;
         byte_cnt    <= '0;
         n_i         <= '0;
         n_d         <= '0;
         k           <= '0;
         asm_word    <= '0;
         cksum       <= '0;
         addr_ext    <= '0;
         wen_ext     <= 1'b0;
         wdata_ext   <= '0;
         addr_ext_2  <= '0;
         wen_ext_2   <= 1'b0;
         wdata_ext_2 <= '0;
      end else begin
         wen_ext   <= 1'b0;
         wen_ext_2 <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state    <= S_HDR;
                  byte_cnt <= '0;
                  k        <= '0;
                  cksum    <= '0;
               end
            end
            S_HDR: begin
               if (accept) begin
                  cksum <= cksum ^ s_data;
                  case (byte_cnt[1:0])
                     2'd0:    n_i[7:0]  <= s_data;
                     2'd1:    n_i[15:8] <= s_data;
                     2'd2:    n_d[7:0]  <= s_data;
                     default: n_d[15:8] <= s_data;
                  endcase
                  if (byte_cnt == 3'd3) begin
                     byte_cnt <= '0;
                     k        <= '0;
                     state    <= hdr_next;
                  end else begin
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end
            S_IMEM: begin
               if (accept) begin
                  cksum <= cksum ^ s_data;
                  if (byte_cnt == 3'd3) begin
                     // Write data is captured separately so streaming continues during the strobe.
                     wen_ext   <= 1'b1;
                     addr_ext  <= {46'd0, k, 2'b00};
                     wdata_ext <= {s_data, asm_word[23:0]};
                     byte_cnt  <= '0;
                     if (k == n_i - 16'd1) begin
                        k     <= '0;
                        state <= (n_d != 16'd0) ? S_DMEM : S_CKSUM;
                     end else begin
                        k <= k + 16'd1;
                     end
                  end else begin
                     asm_word[{byte_cnt, 3'b000} +: 8] <= s_data;
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end
            S_DMEM: begin
               if (accept) begin
                  cksum <= cksum ^ s_data;
                  if (byte_cnt == 3'd7) begin
                     wen_ext_2   <= 1'b1;
                     addr_ext_2  <= {45'd0, k, 3'b000};
                     wdata_ext_2 <= {s_data, asm_word};
                     byte_cnt    <= '0;
                     if (k == n_d - 16'd1) begin
                        k     <= '0;
                        state <= S_CKSUM;
                     end else begin
                        k <= k + 16'd1;
                     end
                  end else begin
                     asm_word[{byte_cnt, 3'b000} +: 8] <= s_data;
                     byte_cnt <= byte_cnt + 3'd1;
                  end
               end
            end
            S_CKSUM: begin
               if (accept)
                  state <= (s_data == cksum) ? S_RUN : S_ERROR;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader: nominal, empty, bad checksum, oversize,
// backpressure and mid-load reset scenarios with hand-computed expectations.
module tb_cpu_program_loader;

   logic        clk;
   logic        arst_n;
   logic        start;
   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic        ren_ext_2;
   logic [63:0] wdata_ext_2;
   logic        cpu_enable;
   logic        busy;
   logic        done;
   logic        error;

   int checks;
   int failures;

   logic [63:0] i_addr_q[$];
   logic [63:0] i_data_q[$];
   logic [63:0] d_addr_q[$];
   logic [63:0] d_data_q[$];
   logic        both_seen;

   logic [7:0] nom [0:20];

   cpu_program_loader #(.IMEM_WORDS(128), .DMEM_WORDS(128)) dut (
      .clk(clk), .arst_n(arst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
      .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2),
      .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable),
      .busy(busy), .done(done), .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wen_ext) begin
         i_addr_q.push_back(addr_ext);
         i_data_q.push_back({32'd0, wdata_ext});
      end
      if (wen_ext_2) begin
         d_addr_q.push_back(addr_ext_2);
         d_data_q.push_back(wdata_ext_2);
      end
      if (wen_ext && wen_ext_2)
         both_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      arst_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      @(posedge clk); #1;
      arst_n = 1'b0;
      i_addr_q.delete(); i_data_q.delete(); d_addr_q.delete(); d_data_q.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Returns #1 after the edge where the byte was accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      waited = 0;
      s_data  = b;
      s_valid = 1'b1;
      while (!s_ready && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!s_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout observed=s_ready_low expected=s_ready_high");
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_data  = 8'hxx;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_nominal(input int gap, input logic [7:0] trailer);
      for (int i = 0; i < 20; i++)
         send_byte(nom[i], gap);
      send_byte(trailer, 0);
   endtask

   task automatic check_nominal_writes(input string tag);
      chk({tag, "_icount"}, 64'(i_addr_q.size()), 64'd2);
      chk({tag, "_dcount"}, 64'(d_addr_q.size()), 64'd1);
      if (i_addr_q.size() == 2) begin
         chk({tag, "_i0_addr"}, i_addr_q[0], 64'd0);
         chk({tag, "_i0_data"}, i_data_q[0], 64'h0000_0000_0050_0093);
         chk({tag, "_i1_addr"}, i_addr_q[1], 64'd4);
         chk({tag, "_i1_data"}, i_data_q[1], 64'h0000_0000_0000_8067);
      end
      if (d_addr_q.size() == 1) begin
         chk({tag, "_d0_addr"}, d_addr_q[0], 64'd0);
         chk({tag, "_d0_data"}, d_data_q[0], 64'h1122_3344_5566_7788);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ctrl"},
          {56'd0, s_ready, wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, done},
          64'd0);
      chk({tag, "_error"}, {63'd0, error}, 64'd0);
      chk({tag, "_addr"}, addr_ext | addr_ext_2, 64'd0);
      chk({tag, "_wdata"}, {32'd0, wdata_ext} | wdata_ext_2, 64'd0);
   endtask

   initial begin
      checks = 0; failures = 0; both_seen = 1'b0;
      arst_n = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
      nom = '{8'h02, 8'h00, 8'h01, 8'h00,
              8'h93, 8'h00, 8'h50, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00,
              8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hAF};

      // Reset state
      do_reset();
      check_all_zero("reset");
      start = 1'b0;
      @(posedge clk); #1;
      chk("idle_ready", {63'd0, s_ready}, 64'd0);

      // Nominal load
      pulse_start();
      chk("hdr_busy", {62'd0, busy, s_ready}, 64'd3);
      send_nominal(0, 8'hAF);
      chk("nom_done", {61'd0, done, cpu_enable, error}, 64'd6);
      chk("nom_ready", {63'd0, s_ready}, 64'd0);
      check_nominal_writes("nom");
      chk("nom_hold_addr", addr_ext, 64'd4);
      chk("nom_hold_data", {32'd0, wdata_ext}, 64'h8067);
      pulse_start();
      @(posedge clk); #1;
      chk("run_ignores_start", {62'd0, done, busy}, 64'd2);

      // Empty image
      do_reset();
      pulse_start();
      for (int i = 0; i < 5; i++)
         send_byte(8'h00, 0);
      chk("empty_run", {61'd0, done, cpu_enable, error}, 64'd6);
      chk("empty_writes", 64'(i_addr_q.size() + d_addr_q.size()), 64'd0);

      // Bad checksum
      do_reset();
      pulse_start();
      send_nominal(0, 8'hAE);
      chk("badck_state", {60'd0, error, cpu_enable, done, s_ready}, 64'h8);
      check_nominal_writes("badck");

      // Oversize header
      do_reset();
      pulse_start();
      send_byte(8'h81, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      chk("over_state", {61'd0, error, s_ready, cpu_enable}, 64'h4);
      @(posedge clk); #1;
      chk("over_writes", 64'(i_addr_q.size() + d_addr_q.size()), 64'd0);

      // Backpressure
      do_reset();
      pulse_start();
      send_nominal(3, 8'hAF);
      chk("bp_done", {61'd0, done, cpu_enable, error}, 64'd6);
      check_nominal_writes("bp");

      // Reset mid-load after 6 payload bytes, then a clean reload
      do_reset();
      pulse_start();
      for (int i = 0; i < 10; i++)
         send_byte(nom[i], 0);
      chk("mid_busy", {63'd0, busy}, 64'd1);
      arst_n = 1'b1;
      @(posedge clk); #1;
      arst_n = 1'b0;
      check_all_zero("midrst");
      i_addr_q.delete(); i_data_q.delete(); d_addr_q.delete(); d_data_q.delete();
      pulse_start();
      send_nominal(0, 8'hAF);
      chk("reload_done", {61'd0, done, cpu_enable, error}, 64'd6);
      check_nominal_writes("reload");

      chk("never_both_strobes", {63'd0, both_seen}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
